// File: rtl/color_eval.sv
// color_eval: scores one guess row against the solution row (word 0),
// producing Wordle colours with duplicate-letter handling, one position per cycle.
module color_eval (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  word_sel,
    output logic [2:0]  word_index,
    input  logic [24:0] cross_match_matrix,
    input  logic [24:0] self_match_matrix,
    output logic        busy,
    output logic        done,
    output logic [9:0]  colors,
    output logic        win
);

    typedef enum logic [1:0] {IDLE, CAPTURE, GREEN, SCAN} state_t;

    state_t      state, state_d;
    logic [2:0]  p, p_d;
    logic [2:0]  word_index_d;
    logic [24:0] cross_q, cross_d;
    logic [24:0] self_q, self_d;
    logic [4:0]  green, green_d;
    logic [9:0]  colors_d;
    logic        busy_d, done_d, win_d;

    logic [4:0]  row_cross, row_self;
    logic [2:0]  avail, used;

    // Row p of each captured matrix: bit j compares letter p with letter j
    assign row_cross = 5'(cross_q >> ({2'b00, p} * 5'd5));
    assign row_self  = 5'(self_q >> ({2'b00, p} * 5'd5));

    // Supply of this letter left after greens, versus yellows already granted
    always_comb begin
        avail = '0;
        used  = '0;
        for (int j = 0; j < 5; j++) begin
            if (row_cross[j] && !green[j])
                avail = avail + 3'd1;
            if (j < int'(p) && row_self[j] && colors[2*j +: 2] == 2'b10)
                used = used + 3'd1;
        end
    end

    always_comb begin
        state_d      = state;
        p_d          = p;
        word_index_d = word_index;
        cross_d      = cross_q;
        self_d       = self_q;
        green_d      = green;
        colors_d     = colors;
        busy_d       = busy;
        done_d       = 1'b0;
        win_d        = win;
        unique case (state)
            IDLE: begin
                if (start && word_sel != 3'd7) begin
                    word_index_d = word_sel;
                    colors_d     = '0;
                    win_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = CAPTURE;
                end
            end
            CAPTURE: begin
                cross_d = cross_match_matrix;
                self_d  = self_match_matrix;
                state_d = GREEN;
            end
            GREEN: begin
                for (int i = 0; i < 5; i++) begin
                    green_d[i]         = cross_q[6*i];
                    colors_d[2*i +: 2] = cross_q[6*i] ? 2'b11 : 2'b00;
                end
                p_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (!green[p])
                    colors_d[2*p +: 2] = (avail > used) ? 2'b10 : 2'b01;
                if (p == 3'd4) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    win_d   = &green;
                    state_d = IDLE;
                end else begin
                    p_d = p + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p          <= '0;
            word_index <= '0;
            cross_q    <= '0;
            self_q     <= '0;
            green      <= '0;
            colors     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            win        <= 1'b0;
        end else begin
            state      <= state_d;
            p          <= p_d;
            word_index <= word_index_d;
            cross_q    <= cross_d;
            self_q     <= self_d;
            green      <= green_d;
            colors     <= colors_d;
            busy       <= busy_d;
            done       <= done_d;
            win        <= win_d;
        end
    end

endmodule

// File: tb/tb_color_eval.sv
// tb_color_eval: directed and random checks of color_eval against a
// letter-level Wordle scoring model driven by a behavioural board.
module tb_color_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  word_sel;
    logic [2:0]  word_index;
    logic [24:0] cross_m;
    logic [24:0] self_m;
    logic        busy;
    logic        done;
    logic [9:0]  colors;
    logic        win;

    logic [4:0]  board [7][5];
    int          nvec = 0;
    int          nerr = 0;

    color_eval dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .word_sel           (word_sel),
        .word_index         (word_index),
        .cross_match_matrix (cross_m),
        .self_match_matrix  (self_m),
        .busy               (busy),
        .done               (done),
        .colors             (colors),
        .win                (win)
    );

    always #5 clk = ~clk;

    // Board storage: matrices follow word_index combinationally
    always_comb begin
        cross_m = '0;
        self_m  = '0;
        if (word_index != 3'd7) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    cross_m[5*i+j] = board[word_index][i] == board[0][j];
                    self_m[5*i+j]  = board[word_index][i] == board[word_index][j];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int r, input string s);
        for (int i = 0; i < 5; i++)
            board[r][i] = 5'(s[i] - 8'd65);
    endtask

    // Standard Wordle: greens first, then non-green solution letters form
    // a supply that earlier guess positions draw from left to right.
    function automatic logic [10:0] model(input int r);
        int         supply [32];
        bit         g [5];
        logic [9:0] c;
        bit         all_g;
        foreach (supply[k]) supply[k] = 0;
        c     = '0;
        all_g = 1'b1;
        for (int i = 0; i < 5; i++) begin
            g[i] = board[r][i] == board[0][i];
            if (!g[i]) begin
                supply[board[0][i]]++;
                all_g = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (g[i]) begin
                c[2*i +: 2] = 2'b11;
            end else if (supply[board[r][i]] > 0) begin
                c[2*i +: 2] = 2'b10;
                supply[board[r][i]]--;
            end else begin
                c[2*i +: 2] = 2'b01;
            end
        end
        return {all_g, c};
    endfunction

    // mode 0: plain; 1: extra start pulse sampled at E3; 2: row rewritten before E2
    task automatic run(input logic [2:0] sel, input int mode, input string tag,
                       output logic [9:0] oc, output logic ow);
        logic [10:0] exp;
        int          early;
        int          idle;
        exp   = model(int'(sel));
        early = 0;
        idle  = 0;
        @(negedge clk);
        start    = 1'b1;
        word_sel = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ":busy_e0"}, 32'(busy), 32'd1);
        check({tag, ":wi_e0"}, 32'(word_index), 32'(sel));
        check({tag, ":clr_e0"}, 32'({win, colors}), 32'd0);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (mode == 2 && n == 2)
                for (int i = 0; i < 5; i++)
                    board[sel][i] = ~board[sel][i];
            if (mode == 1 && n == 3) begin
                start    = 1'b1;
                word_sel = 3'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n < 7 && done) early++;
            if (n < 7 && !busy) idle++;
        end
        check({tag, ":early_done"}, 32'(early), 32'd0);
        check({tag, ":busy_run"}, 32'(idle), 32'd0);
        check({tag, ":done_e7"}, 32'(done), 32'd1);
        check({tag, ":busy_e7"}, 32'(busy), 32'd0);
        check({tag, ":colors"}, 32'(colors), 32'(exp[9:0]));
        check({tag, ":win"}, 32'(win), 32'(exp[10]));
        oc = colors;
        ow = win;
        @(posedge clk);
        #1;
        check({tag, ":done_drop"}, 32'(done), 32'd0);
        check({tag, ":hold"}, 32'({win, colors}), 32'(exp));
    endtask

    initial begin
        logic [9:0]  c;
        logic        w;
        logic [2:0]  wi;
        logic [10:0] e;
        int          spurious;

        rst_n    = 1'b0;
        start    = 1'b0;
        word_sel = 3'd0;
        for (int r = 0; r < 7; r++) set_word(r, "AAAAA");
        #12;
        check("rst_word_index", 32'(word_index), 32'd0);
        check("rst_colors", 32'(colors), 32'd0);
        check("rst_busy_done_win", 32'({busy, done, win}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_word(0, "SPEED");
        set_word(1, "EERIE");
        run(3'd1, 0, "dup", c, w);
        check("dup_const", 32'({w, c}), 32'h15A);

        set_word(0, "ABBEY");
        set_word(2, "BABBY");
        run(3'd2, 0, "greensupply", c, w);
        check("greensupply_const", 32'({w, c}), 32'h37A);

        set_word(3, "ABBEY");
        run(3'd3, 0, "same", c, w);
        check("same_const", 32'({w, c}), 32'h7FF);
        run(3'd0, 0, "sel0", c, w);
        check("sel0_const", 32'({w, c}), 32'h7FF);

        run(3'd2, 1, "midstart", c, w);
        run(3'd2, 2, "isolate", c, w);
        set_word(2, "BABBY");

        wi = word_index;
        @(negedge clk);
        start    = 1'b1;
        word_sel = 3'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("sel7_busy", 32'(busy), 32'd0);
        check("sel7_wi", 32'(word_index), 32'(wi));
        check("sel7_colors", 32'(colors), 32'(c));

        // Start held through done: the done cycle starts the next run
        set_word(1, "ABBEY");
        set_word(4, "YEBBA");
        e = model(4);
        @(negedge clk);
        start    = 1'b1;
        word_sel = 3'd1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        check("held_done1", 32'(done), 32'd1);
        check("held_win1", 32'({win, colors}), 32'h7FF);
        @(negedge clk);
        word_sel = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_restart", 32'({busy, done}), 32'h2);
        check("held_cleared", 32'({win, colors}), 32'd0);
        check("held_wi", 32'(word_index), 32'd4);
        repeat (7) @(posedge clk);
        #1;
        check("held_done2", 32'(done), 32'd1);
        check("held_result2", 32'({win, colors}), 32'(e));
        @(posedge clk);

        // Asynchronous reset while position 2 is being resolved
        @(negedge clk);
        start    = 1'b1;
        word_sel = 3'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy_done", 32'({busy, done}), 32'd0);
        check("arst_colors", 32'(colors), 32'd0);
        check("arst_wi", 32'(word_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) spurious++;
        end
        check("arst_no_done", 32'(spurious), 32'd0);
        run(3'd2, 0, "after_rst", c, w);

        repeat (150) begin
            for (int r = 0; r < 7; r++)
                for (int i = 0; i < 5; i++)
                    board[r][i] = 5'($urandom_range(0, 3));
            run(3'($urandom_range(0, 6)), int'($urandom_range(0, 2)), "rnd", c, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/color_eval.md
# color_eval

Scores one guess row of the game board against the solution row (word 0) and produces per-letter Wordle colours with correct duplicate-letter handling. It sits directly downstream of the board storage. It drives the board's word-select index and captures the board's 25-bit cross-match (guess vs solution) and self-match (guess vs guess) matrices. It then resolves yellow/grey for one letter position per cycle under a start/done handshake. Results feed the display/colour stage and the win detector.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request evaluation of word_sel; sampled only while idle
- word_sel  in  3  row to score, 0..6; 7 is invalid
- word_index  out  3  row select driven to board storage
- cross_match_matrix  in  25  bit 5*i+j = guess letter i equals solution letter j
- self_match_matrix  in  25  bit 5*i+j = guess letter i equals guess letter j
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse; colors and win final
- colors  out  10  bits [2p+1:2p] = colour of position p: 00 unscored, 01 grey, 10 yellow, 11 green
- win  out  1  all five positions green; valid from done, held until next accepted start

## Operation

- States: IDLE, CAPTURE, GREEN, SCAN (position counter p = 0..4).
- IDLE:
  - start=1 and word_sel≤6: word_index←word_sel, colors←0, win←0, busy←1, go to CAPTURE.
  - start with word_sel=7: ignored, no output change.
- CAPTURE: board matrices now reflect word_index. Register both matrices locally. Go to GREEN.
  - Board writes after this edge do not affect the result.
- GREEN:
  - green[i] = captured cross[5i+i].
  - Set colors[i]=11 for every green position; others stay 00.
  - p←0, go to SCAN.
- SCAN, position p:
  - If green[p]: no change.
  - Otherwise compute:
    - avail = count of j in 0..4 with cross[5p+j] & ~green[j] (3-bit, 0..5).
    - used = count of k<p with self[5p+k] & colors[k]==10.
  - avail > used gives 10 (yellow); otherwise 01 (grey).
  - At p=4: done←1, busy←0, win←(green==5'b11111), go to IDLE. Otherwise p←p+1.
- word_sel=0 is legal. It scores the solution against itself: all green, win=1.
- word_index holds its last value in IDLE.

## Timing

- Reset values: word_index=0, colors=0, busy=0, done=0, win=0, state IDLE, p=0.
- Edge E0 samples start. Then:
  - E1: capture.
  - E2: green positions visible.
  - E3..E7: positions 0..4 resolved, one per edge.
  - done high for exactly the cycle after E7.
- Latency start→done is 8 edges, fixed regardless of data.
- busy is high from after E0 until E7. busy and done are never both high.
- start while busy is ignored, with no restart and no queueing.
- start in the cycle done is high is accepted: that edge is E0 of the new run, and done drops.
- rst_n low at any time, including mid-SCAN, returns all outputs to reset values immediately. No done is produced for the aborted run.
- colors is monotonic within a run: an entry only changes from 00 to its final value.

## Test plan

- Duplicate guess letters, solution S,P,E,E,D vs guess E,E,R,I,E:
  - done exactly 8 edges after start.
  - colors=10'h15A (pos0,1 yellow; pos2,3,4 grey); win=0.
- Green consumes supply, solution A,B,B,E,Y vs guess B,A,B,B,Y:
  - colors=10'h37A (pos0,1 yellow; pos2,4 green; pos3 grey); win=0.
- Guess equals solution (row 3 = row 0), also word_sel=0:
  - colors=10'h3FF, win=1, done pulse one cycle.
- Handshake:
  - start pulsed at E3 of a run: ignored, still one done at E7.
  - start held high through done: second run starts, colors cleared to 0, win cleared.
  - word_sel=7: busy stays 0.
- Capture isolation: board row rewritten at E2 → result matches pre-write contents.
- Reset mid-operation: rst_n low during SCAN p=2 gives busy=0, done=0, colors=0, word_index=0 asynchronously. After release, a fresh start completes normally.
